spi_write_sequencer: RTL and testbench

SPI Mode 0 controller that drives the chip's write-only SPI register-file peripheral (output enables, PWM enables, PWM duty cycle). It accepts register-write requests over a valid/ready handshake and buffers them in a small FIFO. Each request is serialised as one 16-bit frame on SCLK/COPI/nCS, with programmable SCLK rate and inter-frame gap. It sits in the bring-up/test harness and in the on-chip config sequencer path, replacing software bit-banging.

---
 rtl/spi_reg_pkg.sv | 33 +++
 rtl/spi_req_fifo.sv | 57 +++++
 rtl/spi_write_sequencer.sv | 174 +++++++++++++++++
 tb/tb_spi_write_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-file write path: frame layout,
// register map and sequencer state encoding.
package spi_reg_pkg;

  localparam int         FRAME_BITS = 16;
  localparam logic       RW_WRITE   = 1'b1;
  localparam logic [6:0] MAX_ADDR   = 7'h04;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } req_t;

  function automatic logic [FRAME_BITS-1:0] build_frame(input req_t r);
    return {RW_WRITE, r.addr, r.data};
  endfunction

endpackage

// File: rtl/spi_req_fifo.sv
// Small show-ahead FIFO holding pending register writes; the head entry is
// readable in the same cycle it is popped.
module spi_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr_reg];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/spi_write_sequencer.sv
// SPI mode-0 master that turns queued register writes into 16-bit frames
// {write, addr, data} for the write-only register-file peripheral.
module spi_write_sequencer
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  output logic       busy,
  output logic       done,
  output logic       err_addr
);

  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t                state_reg, state_next;
  logic [7:0]            div_reg, div_next;
  logic [4:0]            bit_reg, bit_next;
  logic [7:0]            gap_reg, gap_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic                  sclk_reg, sclk_next;
  logic                  copi_reg, copi_next;
  logic                  ncs_reg, ncs_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  logic                  busy_reg, busy_next;

  logic                  fifo_full, fifo_empty, push, pop, handshake;
  logic [CW-1:0]         fifo_count;
  req_t                  head;
  logic [14:0]           head_bits;

  assign req_ready = rst_n & ~fifo_full;
  assign handshake = req_valid & req_ready;
  assign push      = handshake & (req_addr <= MAX_ADDR);
  assign err_next  = handshake & (req_addr > MAX_ADDR);
  assign head      = req_t'(head_bits);

  spi_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(15)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({req_addr, req_data}),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    gap_next   = gap_reg;
    shift_next = shift_reg;
    sclk_next  = sclk_reg;
    copi_next  = copi_reg;
    ncs_next   = ncs_reg;
    done_next  = 1'b0;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = build_frame(head);
          copi_next  = shift_next[FRAME_BITS-1];
          ncs_next   = 1'b0;
          sclk_next  = 1'b0;
          div_next   = '0;
          bit_next   = '0;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP, ST_LOW: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          sclk_next  = 1'b1;
          bit_next   = bit_reg + 1'b1;
          state_next = ST_HIGH;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      ST_HIGH: begin
        if (div_reg == DIV_LAST) begin
          div_next  = '0;
          sclk_next = 1'b0;
          // Next bit changes on the falling edge so it is stable a full half-period before the rise.
          if (bit_reg < 5'(FRAME_BITS)) begin
            shift_next = {shift_reg[FRAME_BITS-2:0], 1'b0};
            copi_next  = shift_reg[FRAME_BITS-2];
            state_next = ST_LOW;
          end else begin
            state_next = ST_HOLD;
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      ST_HOLD: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          ncs_next   = 1'b1;
          done_next  = 1'b1;
          copi_next  = 1'b0;
          gap_next   = '0;
          state_next = ST_GAP;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_reg == GAP_LAST) begin
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered busy reflects the FIFO occupancy after this cycle's push/pop.
  assign busy_next = (state_next != ST_IDLE) | push | (fifo_count > CW'(pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      div_reg   <= '0;
      bit_reg   <= '0;
      gap_reg   <= '0;
      shift_reg <= '0;
      sclk_reg  <= 1'b0;
      copi_reg  <= 1'b0;
      ncs_reg   <= 1'b1;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      gap_reg   <= gap_next;
      shift_reg <= shift_next;
      sclk_reg  <= sclk_next;
      copi_reg  <= copi_next;
      ncs_reg   <= ncs_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      busy_reg  <= busy_next;
    end
  end

  assign sclk     = sclk_reg;
  assign copi     = copi_reg;
  assign ncs      = ncs_reg;
  assign done     = done_reg;
  assign err_addr = err_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_spi_write_sequencer.sv
// Scoreboard bench: the driver queues expected frames, an SPI monitor with a
// register-file peripheral model decodes the bus and compares.
module tb_spi_write_sequencer;
  import spi_reg_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 8;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       req_ready, sclk, copi, ncs, busy, done, err_addr;

  int compared = 0;
  int mismatched = 0;
  logic [15:0] exp_q[$];
  int  err_exp = 0, err_seen = 0, frames_started = 0;
  int  sclk_idle_viol = 0, stray_done = 0;
  bit  check_gap = 0;
  logic [7:0] periph [5];

  always #5 clk = ~clk;

  spi_write_sequencer #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .sclk(sclk), .copi(copi),
    .ncs(ncs), .busy(busy), .done(done), .err_addr(err_addr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic timeout_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out waiting, required event never seen", name);
  endtask

  // Driver: called at a negedge, returns at the negedge after the handshake.
  task automatic send(input logic [6:0] a, input logic [7:0] d, output int waited);
    waited = 0;
    req_valid = 1'b1; req_addr = a; req_data = d;
    while (!req_ready && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 5000) begin
      timeout_fail("send_ready");
    end else begin
      @(posedge clk);
      if (a <= MAX_ADDR) exp_q.push_back({1'b1, a, d});
      else err_exp++;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) timeout_fail(name);
  endtask

  // Monitor + peripheral model
  logic ncs_q = 1'b1, sclk_q = 1'b0;
  bit   in_frame = 0;
  int   low_cnt = 0, rises = 0, high_cnt = 0;
  logic [15:0] shifted = '0;
  logic [15:0] exp_frame;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0; ncs_q = 1'b1; sclk_q = 1'b0; high_cnt = 0;
    end else begin
      if (err_addr) err_seen++;
      if (ncs && sclk) sclk_idle_viol++;
      if (done && !(ncs && !ncs_q)) stray_done++;
      if (ncs_q && !ncs) begin
        frames_started++;
        if (check_gap) chk("ncs_high_gap", high_cnt, GAP_CYCLES + 1);
        in_frame = 1; low_cnt = 0; rises = 0; shifted = '0; high_cnt = 0;
      end
      if (!ncs) begin
        low_cnt++;
        if (sclk && !sclk_q) begin
          rises++;
          shifted = {shifted[14:0], copi};
        end
      end else begin
        high_cnt++;
      end
      if (!ncs_q && ncs && in_frame) begin
        in_frame = 0;
        chk("done_at_ncs_rise", done, 1);
        chk("ncs_low_cycles", low_cnt, 33 * CLK_DIV);
        chk("sclk_rises", rises, 16);
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_frame: got 0x%0h required no frame", shifted);
        end else begin
          exp_frame = exp_q.pop_front();
          chk("frame_bits", shifted, exp_frame);
        end
        if (rises == 16 && shifted[15] && shifted[14:8] <= 7'd4)
          periph[shifted[10:8]] = shifted[7:0];
      end
      ncs_q = ncs;
      sclk_q = sclk;
    end
  end

  initial begin
    int w, t, cnt, snap;
    logic prev;
    logic [7:0] want [5];
    for (int i = 0; i < 5; i++) periph[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_copi", copi, 0);
    chk("rst_ncs", ncs, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_addr, 0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write; frame checked by monitor as 0x80A5
    send(7'h00, 8'hA5, w);
    chk("ncs_high_right_after_push", ncs, 1);
    @(negedge clk);
    chk("ncs_low_latency", ncs, 0);
    t = 0;
    while (!ncs && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) timeout_fail("frame1_end");
    cnt = 0;
    while (busy && cnt < 100) begin @(negedge clk); cnt++; end
    chk("busy_cycles_after_ncs_rise", cnt, GAP_CYCLES);
    wait_idle("idle_t1");

    // Three back-to-back requests
    send(7'h01, 8'h3C, w); chk("t2_ready_0", w, 0);
    send(7'h02, 8'hC3, w); chk("t2_ready_1", w, 0);
    send(7'h03, 8'h5A, w); chk("t2_ready_2", w, 0);
    @(negedge clk);
    check_gap = 1;
    wait_idle("idle_t2");

    // Six requests with FIFO back-pressure
    check_gap = 0;
    send(7'h04, 8'h11, w);
    t = 0;
    while (ncs && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    check_gap = 1;
    send(7'h00, 8'h22, w);
    send(7'h01, 8'h33, w);
    send(7'h02, 8'h44, w);
    send(7'h03, 8'h55, w);
    chk("ready_low_when_full", req_ready, 0);
    send(7'h04, 8'h66, w);
    chk("held_request_waited", (w > 0), 1);
    wait_idle("idle_t3");
    check_gap = 0;

    // Out-of-range address
    send(7'h05, 8'hFF, w);
    chk("err_pulse", err_addr, 1);
    chk("err_busy", busy, 0);
    @(negedge clk);
    chk("err_single_cycle", err_addr, 0);
    chk("err_ncs_high", ncs, 1);
    repeat (4) @(negedge clk);
    chk("err_no_activity", busy, 0);

    // Reset at the 7th sclk rise with two entries queued
    for (int i = 0; i < 5; i++) periph[i] = '0;
    send(7'h03, 8'h5A, w);
    send(7'h03, 8'h5B, w);
    send(7'h03, 8'h5C, w);
    cnt = 0; t = 0; prev = sclk;
    while (cnt < 7 && t < 1000) begin
      @(negedge clk); t++;
      if (sclk && !prev) cnt++;
      prev = sclk;
    end
    if (t >= 1000) timeout_fail("seventh_rise");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ncs", ncs, 1);
    chk("midrst_sclk", sclk, 0);
    chk("midrst_ready", req_ready, 0);
    exp_q.delete();
    snap = frames_started;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("postrst_busy", busy, 0);
    chk("postrst_no_frame", frames_started, snap);
    chk("partial_frame_discarded", periph[3], 8'h00);

    // Closed loop with peripheral model
    send(ADDR_EN_OUT_7_0, 8'hFF, w);
    send(ADDR_PWM_DUTY, 8'h80, w);
    wait_idle("idle_t6");
    want[0] = 8'hFF; want[1] = 8'h00; want[2] = 8'h00; want[3] = 8'h00; want[4] = 8'h80;
    for (int i = 0; i < 5; i++) chk($sformatf("periph_reg%0d", i), periph[i], want[i]);

    repeat (5) @(negedge clk);
    chk("frames_outstanding", exp_q.size(), 0);
    chk("err_pulse_count", err_seen, err_exp);
    chk("sclk_toggle_while_ncs_high", sclk_idle_viol, 0);
    chk("stray_done_pulses", stray_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
